uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_framed.sv | 146 ++++++++++++++
 tb/tb_uart_tx_framed.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM state encoding and small helpers,
// kept here so the future receiver decodes frames exactly as the transmitter builds them.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Rounded clock cycles per line bit.
  function automatic int baud_div(input int clock_hz, input int baud_rate);
    return (clock_hz + baud_rate / 2) / baud_rate;
  endfunction

  // Odd mode makes data plus parity carry an odd count of ones; even mode an even count.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter; writes when full and reads when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_read,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_write;
  logic             do_read;

  // A write arriving while full is dropped even if a read frees a slot in the same cycle.
  assign do_write = i_write && !o_full;
  assign do_read  = i_read && !o_empty;
  assign o_full   = (count == (AW+1)'(DEPTH));
  assign o_empty  = (count == '0);
  assign o_data   = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: a small FIFO feeds a start/data/parity/stop framing FSM
// timed by a one-cycle baud enable derived from a reloadable down-counter.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 16_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_write,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_full,
  output logic                 o_busy,
  output logic                 o_uart_tx
);

  localparam int DIV = baud_div(CLOCK_HZ, BAUD_RATE);
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_framed: CLOCK_HZ/BAUD_RATE must give at least 2 cycles per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_check
    $error("uart_tx_framed: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_parity_check
    $error("uart_tx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx_framed: FIFO_DEPTH must be a power of two in 2..16");
  end

  uart_state_t          state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shifter;
  logic                 parity_q;
  logic                 tx_q;
  logic                 line_bit;
  logic                 bit_end;
  logic                 frame_done;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 fifo_full;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_write (i_write),
    .i_data  (i_data),
    .i_read  (pop),
    .o_data  (fifo_data),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  // Popping on the last stop-bit cycle lets the next start bit follow with no idle gap.
  assign bit_end    = (baud_cnt == '0);
  assign frame_done = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign pop        = !fifo_empty && ((state == ST_IDLE) || frame_done);

  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shifter[0];
      ST_PARITY: line_bit = parity_q;
      default:   line_bit = 1'b1;
    endcase
  end

  // The line register trails the state by one cycle, so every bit keeps its full DIV width.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= line_bit;
      if (pop) begin
        state    <= ST_START;
        shifter  <= fifo_data;
        parity_q <= parity_bit(9'(fifo_data), PARITY);
        baud_cnt <= DIV_LAST;
        bit_cnt  <= '0;
      end else if (state != ST_IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt - 1'b1;
        end else begin
          baud_cnt <= DIV_LAST;
          case (state)
            ST_START: begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
            ST_DATA: begin
              shifter <= shifter >> 1;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            ST_PARITY: begin
              state   <= ST_STOP;
              bit_cnt <= '0;
            end
            ST_STOP: begin
              if (bit_cnt == STOP_LAST) begin
                state    <= ST_IDLE;
                baud_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign o_uart_tx = tx_q;
  assign o_full    = fifo_full;
  assign o_busy    = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: a frame-level model checks the 8N1 instance every cycle,
// and literal line sequences pin the model plus the 7E2 and 8O1 variants.
module tb_uart_tx_framed;

  localparam int DIV       = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = DIV * 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, write;
  logic [7:0] data;
  logic       full, busy, tx;
  logic       p_reset;
  logic       p7_write;
  logic [6:0] p7_data;
  logic       p7_full, p7_busy, p7_tx;
  logic       p8_write;
  logic [7:0] p8_data;
  logic       p8_full, p8_busy, p8_tx;

  int checks = 0;
  int passes = 0;
  int pat[12];
  int zeros;

  uart_tx_framed #(
    .CLOCK_HZ(16), .BAUD_RATE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_write(write), .i_data(data),
    .o_full(full), .o_busy(busy), .o_uart_tx(tx)
  );

  uart_tx_framed #(
    .CLOCK_HZ(16), .BAUD_RATE(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_7e2 (
    .i_clk(clk), .i_reset(p_reset), .i_write(p7_write), .i_data(p7_data),
    .o_full(p7_full), .o_busy(p7_busy), .o_uart_tx(p7_tx)
  );

  uart_tx_framed #(
    .CLOCK_HZ(16), .BAUD_RATE(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_8o1 (
    .i_clk(clk), .i_reset(p_reset), .i_write(p8_write), .i_data(p8_data),
    .o_full(p8_full), .o_busy(p8_busy), .o_uart_tx(p8_tx)
  );

  function automatic void checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
  endfunction

  // Frame-level model of the 8N1 instance: a character queue, the cycles left in the
  // frame on the wire side, and a queue of the line values each upcoming cycle must show.
  logic [7:0] fifo_m[$];
  bit         line_q[$];
  int         frame_left = 0;
  bit         exp_tx = 1'b1;
  bit         exp_busy = 1'b0;
  bit         exp_full = 1'b0;
  bit         accept_m, pop_m;
  logic [7:0] char_m;

  function automatic void pushFrame(input logic [7:0] c);
    for (int s = 0; s < FRAME_LEN; s++) begin
      int b;
      b = s / DIV;
      if (b == 0) line_q.push_back(1'b0);
      else if (b <= 8) line_q.push_back(c[b-1]);
      else line_q.push_back(1'b1);
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      fifo_m.delete();
      line_q.delete();
      frame_left = 0;
      exp_tx = 1'b1;
    end else begin
      exp_tx   = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
      accept_m = write && (fifo_m.size() < DEPTH);
      pop_m    = (fifo_m.size() > 0) && (frame_left <= 1);
      if (frame_left > 0) frame_left--;
      if (pop_m) begin
        char_m = fifo_m.pop_front();
        pushFrame(char_m);
        frame_left = FRAME_LEN;
      end
      if (accept_m) fifo_m.push_back(data);
    end
    exp_full = (fifo_m.size() == DEPTH);
    exp_busy = (fifo_m.size() > 0) || (frame_left > 0);
  end

  always @(negedge clk) begin
    checkOutput("model_tx", int'(tx), int'(exp_tx));
    checkOutput("model_busy", int'(busy), int'(exp_busy));
    checkOutput("model_full", int'(full), int'(exp_full));
  end

  function automatic logic lineOf(input int which);
    case (which)
      1:       return p7_tx;
      2:       return p8_tx;
      default: return tx;
    endcase
  endfunction

  task automatic applyStimulus(input int which, input logic [8:0] d);
    @(negedge clk);
    case (which)
      1:       begin p7_write = 1'b1; p7_data = d[6:0]; end
      2:       begin p8_write = 1'b1; p8_data = d[7:0]; end
      default: begin write = 1'b1; data = d[7:0]; end
    endcase
    @(negedge clk);
    write = 1'b0;
    p7_write = 1'b0;
    p8_write = 1'b0;
  endtask

  task automatic writeBurst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      write = 1'b1;
      data = 8'($urandom);
    end
    @(negedge clk);
    write = 1'b0;
  endtask

  // Called just after the write edge N: line stays high after N+1, then each bit holds DIV cycles.
  task automatic expectLine(input string name, input int which, input int nbits);
    @(negedge clk);
    checkOutput({name, "_latency"}, int'(lineOf(which)), 1);
    for (int k = 0; k < nbits * DIV; k++) begin
      @(negedge clk);
      checkOutput(name, int'(lineOf(which)), pat[k / DIV]);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_bound", int'(n < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; p_reset = 1'b1; write = 1'b0; data = '0;
    p7_write = 1'b0; p7_data = '0; p8_write = 1'b0; p8_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", int'(tx), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_full", int'(full), 0);
    reset = 1'b0;
    p_reset = 1'b0;
    @(negedge clk);

    // 8N1 0x48: start, 0,0,0,1,0,0,1,0, stop.
    pat = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    applyStimulus(0, 9'h048);
    expectLine("8n1_0x48", 0, 10);
    checkOutput("8n1_busy_after", int'(busy), 0);

    // 7E2 0x35: start, 1,0,1,0,1,1,0, parity 0, two stops.
    pat = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1};
    applyStimulus(1, 9'h035);
    expectLine("7e2_0x35", 1, 11);
    checkOutput("7e2_busy_after", int'(p7_busy), 0);

    // 8O1: both all-zeros and all-ones data need parity 1.
    pat = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    applyStimulus(2, 9'h000);
    expectLine("8o1_0x00", 2, 11);
    pat = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    applyStimulus(2, 9'h0FF);
    expectLine("8o1_0xff", 2, 11);
    checkOutput("8o1_busy_after", int'(p8_busy), 0);

    // The first write goes straight to the shifter, so the FIFO fills on the fifth write.
    writeBurst(5);
    checkOutput("burst_full", int'(full), 1);
    applyStimulus(0, 9'h0A5);
    checkOutput("burst_drop_full", int'(full), 1);
    waitIdle();

    // Reset in cycle 10 of a frame with two characters queued, with a write held during reset.
    writeBurst(3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    write = 1'b1;
    data = 8'h3C;
    @(negedge clk);
    reset = 1'b0;
    write = 1'b0;
    checkOutput("abort_tx", int'(tx), 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_full", int'(full), 0);
    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (!tx) zeros++;
    end
    checkOutput("abort_no_frames", zeros, 0);

    // Write landing on the pop edge with two queued: occupancy stays two.
    writeBurst(3);
    repeat (38) @(negedge clk);
    write = 1'b1;
    data = 8'($urandom);
    @(negedge clk);
    write = 1'b0;
    checkOutput("pop_write_not_full", int'(full), 0);
    writeBurst(2);
    checkOutput("pop_write_occupancy", int'(full), 1);
    waitIdle();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      write = ($urandom_range(0, 2) == 0);
      data  = 8'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;
    waitIdle();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
